// File: rtl/nes_rom_port_pkg.sv
// rtl/nes_rom_port_pkg.sv - shared constants and FSM encoding for the NES ROM port
// Holds the ROM-port FSM state type, the default PRG base, the PRG/CHR image sizes
// and the port-index constants also used by the flash loader.
package nes_rom_port_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } rom_state_t;

    localparam logic [22:0] PRG_BASE_DEFAULT = 23'h8000;

    localparam int PRG_SIZE  = 32 * 1024;
    localparam int CHR_SIZE  = 8 * 1024;
    localparam int PRG_OFS_W = $clog2(PRG_SIZE);
    localparam int CHR_OFS_W = $clog2(CHR_SIZE);

    // Port indices; the flash loader uses the same numbering.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_PPU = 1'b1;

endpackage

// File: rtl/nes_rom_port_arb.sv
// rtl/nes_rom_port_arb.sv - two-requester round-robin arbiter for the ROM port
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_req[1:0]   : requests indexed by PORT_CPU / PORT_PPU
//   i_take       : the current grant is being accepted this cycle
//   o_valid      : at least one request is present
//   o_grant      : index of the winning port
module rom_rr_arb
    import nes_rom_port_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_grant
);

    // Last granted port; clearing it to PORT_CPU makes the first tie go to the PPU.
    logic r_last;

    always_comb begin
        o_valid = |i_req;
        if (i_req[PORT_CPU] && i_req[PORT_PPU]) begin
            o_grant = ~r_last;
        end else if (i_req[PORT_PPU]) begin
            o_grant = PORT_PPU;
        end else begin
            o_grant = PORT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_CPU;
        end else if (i_take) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/nes_rom_port.sv
// rtl/nes_rom_port.sv - SDRAM ROM port: loader passthrough, then CPU/PPU read arbitration
// Optional feature macro: ROM_CACHE_EN (one-entry read cache per port).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   load_done, ld_addr/rw/din/valid   : flash loader side, passed to SDRAM while loading
//   ld_busy                           : SDRAM busy while loading, 1 afterwards
//   cpu_req/addr, cpu_ack/data        : CPU PRG read port (level request, pulse ack)
//   ppu_req/addr, ppu_ack/data        : PPU CHR read port (level request, pulse ack)
//   addr, rw, data_in, in_valid       : SDRAM command
//   busy, data_out, out_valid         : SDRAM status / read return
module nes_rom_port
    import nes_rom_port_pkg::*;
#(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] PRG_BASE = ADDR_W'(PRG_BASE_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_done,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic                 ld_rw,
    input  logic [7:0]           ld_din,
    input  logic                 ld_valid,
    output logic                 ld_busy,
    input  logic                 cpu_req,
    input  logic [PRG_OFS_W-1:0] cpu_addr,
    output logic                 cpu_ack,
    output logic [7:0]           cpu_data,
    input  logic                 ppu_req,
    input  logic [CHR_OFS_W-1:0] ppu_addr,
    output logic                 ppu_ack,
    output logic [7:0]           ppu_data,
    output logic [ADDR_W-1:0]    addr,
    output logic                 rw,
    output logic [7:0]           data_in,
    output logic                 in_valid,
    input  logic                 busy,
    input  logic [7:0]           data_out,
    input  logic                 out_valid
);

    rom_state_t        r_state;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cpu_ack;
    logic              r_ppu_ack;
    logic [7:0]        r_cpu_data;
    logic [7:0]        r_ppu_data;

    logic              w_loading;
    logic              w_arb_valid;
    logic              w_arb_grant;
    logic [1:0]        w_req;
    logic [ADDR_W-1:0] w_map_addr;
    logic              w_take;
    logic              w_hit;
    logic [7:0]        w_hit_data;

    assign w_loading = (r_state == ST_LOAD);

    // A requester still sees its ack this cycle and has not yet dropped req;
    // masking it stops the just-finished read from being granted again.
    assign w_req[PORT_CPU] = cpu_req & ~r_cpu_ack;
    assign w_req[PORT_PPU] = ppu_req & ~r_ppu_ack;

    assign w_take = (r_state == ST_IDLE) && w_arb_valid;

    rom_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .i_take  (w_take),
        .o_valid (w_arb_valid),
        .o_grant (w_arb_grant)
    );

    assign w_map_addr = (w_arb_grant == PORT_CPU) ? (PRG_BASE + ADDR_W'(cpu_addr))
                                                  : ADDR_W'(ppu_addr);

    // SDRAM side: loader owns the bus while loading, read engine afterwards.
    assign addr     = w_loading ? ld_addr  : r_addr;
    assign rw       = w_loading ? ld_rw    : 1'b0;
    assign data_in  = w_loading ? ld_din   : 8'h00;
    assign in_valid = w_loading ? ld_valid : ((r_state == ST_ISSUE) && !busy);
    assign ld_busy  = w_loading ? busy     : 1'b1;

    assign cpu_ack  = r_cpu_ack;
    assign ppu_ack  = r_ppu_ack;
    assign cpu_data = r_cpu_data;
    assign ppu_data = r_ppu_data;

`ifdef ROM_CACHE_EN
    logic [ADDR_W-1:0] r_ctag [2];
    logic [7:0]        r_cdat [2];
    logic [1:0]        r_cval;

    assign w_hit      = r_cval[w_arb_grant] && (r_ctag[w_arb_grant] == w_map_addr);
    assign w_hit_data = r_cdat[w_arb_grant];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cval <= 2'b00;
        end else if (w_loading && load_done && !busy) begin
            // Image may have changed during loading; start with empty caches.
            r_cval <= 2'b00;
        end else if ((r_state == ST_WAIT) && out_valid) begin
            r_cval[r_grant] <= 1'b1;
            r_ctag[r_grant] <= r_addr;
            r_cdat[r_grant] <= data_out;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_grant    <= PORT_CPU;
            r_addr     <= '0;
            r_cpu_ack  <= 1'b0;
            r_ppu_ack  <= 1'b0;
            r_cpu_data <= 8'h00;
            r_ppu_data <= 8'h00;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ppu_ack <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (load_done && !busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_grant;
                        r_addr  <= w_map_addr;
                        if (w_hit) begin
                            if (w_arb_grant == PORT_PPU) begin
                                r_ppu_data <= w_hit_data;
                            end else begin
                                r_cpu_data <= w_hit_data;
                            end
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // in_valid is decoded from this state and !busy, so the
                    // command is presented for exactly the cycle we leave.
                    if (!busy) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (out_valid) begin
                        if (r_grant == PORT_PPU) begin
                            r_ppu_data <= data_out;
                        end else begin
                            r_cpu_data <= data_out;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_grant == PORT_PPU) begin
                        r_ppu_ack <= 1'b1;
                    end else begin
                        r_cpu_ack <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: doc/nes_rom_port.md
NES_ROM_PORT -- requirements
Module: nes_rom_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, meaning the SDRAM byte-address width.
REQ-002 SHALL have parameter PRG_BASE, default 23'h8000, meaning the SDRAM base of the 32 kB PRG image.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- load_done  in  1  flash loader finished (level).
- ld_addr  in  ADDR_W  loader write address.
- ld_rw  in  1  loader rw; 1 = write.
- ld_din  in  8  loader write data.
- ld_valid  in  1  loader request strobe.
- ld_busy  out  1  SDRAM busy, as seen by the loader.
- cpu_req  in  1  CPU PRG read request; level, held until ack.
- cpu_addr  in  15  PRG offset.
- cpu_ack  out  1  one-cycle pulse; cpu_data valid.
- cpu_data  out  8  PRG byte.
- ppu_req  in  1  PPU CHR read request; level, held until ack.
- ppu_addr  in  13  CHR offset.
- ppu_ack  out  1  one-cycle pulse; ppu_data valid.
- ppu_data  out  8  CHR byte.
- addr  out  ADDR_W  SDRAM address.
- rw  out  1  SDRAM rw; 1 = write, 0 = read.
- data_in  out  8  SDRAM write data.
- in_valid  out  1  SDRAM command strobe.
- busy  in  1  SDRAM busy.
- data_out  in  8  SDRAM read data.
- out_valid  in  1  SDRAM read data valid.

Function
REQ-004 SHALL implement FSM states LOAD, IDLE, ISSUE, WAIT, RESP.
REQ-005 In LOAD, SHALL combinationally pass ld_addr/ld_rw/ld_din/ld_valid to addr/rw/data_in/in_valid, and busy to ld_busy; cpu_req and ppu_req SHALL be ignored.
REQ-006 SHALL move LOAD->IDLE on the first cycle that load_done=1 and busy=0; SHALL NOT return to LOAD except via reset.
REQ-007 Outside LOAD, ld_busy SHALL be 1 and loader inputs SHALL be ignored.
REQ-008 In IDLE, with any request asserted, SHALL grant one port, latch its mapped address, and go to ISSUE.
REQ-009 Arbitration SHALL be round-robin: with both requests asserted, the port not granted last wins; the first arbitration after reset favours PPU.
REQ-010 Address mapping SHALL be: CPU -> PRG_BASE + cpu_addr; PPU -> zero-extended ppu_addr.
REQ-011 In ISSUE, when busy=0, SHALL drive in_valid=1, rw=0 with the latched address for exactly one cycle, then go to WAIT; while busy=1 it SHALL hold in ISSUE with in_valid=0.
REQ-012 In WAIT, on out_valid=1, SHALL register data_out into the granted port's data register and go to RESP.
REQ-013 In RESP, SHALL pulse the granted port's ack for one cycle and return to IDLE; the data register SHALL hold its value until the next ack of that port.
REQ-014 Minimum latency SHALL be: request seen in IDLE -> ack 3 cycles plus SDRAM read latency.
REQ-015 out_valid outside WAIT SHALL be ignored.
REQ-016 A request deasserted before its ack SHALL still complete the transaction; a late ack is harmless.
REQ-017 Outside LOAD, rw SHALL be 0 and data_in SHALL be 0.

Reset
REQ-018 On rst, SHALL enter LOAD, clear cpu_ack, ppu_ack, cpu_data, ppu_data and the round-robin pointer, and discard any outstanding read.
REQ-019 Registered outputs SHALL reset to 0: in_valid=0, rw=0, addr=0; passthrough values SHALL apply from the first cycle after reset.

Configuration
REQ-020 With ROM_CACHE_EN defined, each port SHALL keep a one-entry cache (tag, data, valid); a granted request whose address equals the valid tag SHALL go IDLE->RESP with no SDRAM access (ack 2 cycles after the request).
REQ-021 Cache valid bits SHALL clear on reset and on the LOAD->IDLE transition.
REQ-022 Without ROM_CACHE_EN, every request SHALL access SDRAM, and no cache registers SHALL exist.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding, PRG_BASE, the 32 kB/8 kB PRG/CHR sizes, and the port-index constants shared with the flash loader.
REQ-024 A single sub-module, rom_rr_arb (two-requester round-robin arbiter), SHALL be used; everything else stays flat.

Verification
REQ-025 Load pass-through: ld_valid, ld_addr=23'h8005, ld_din=8'hA5 in LOAD -> identical values on the SDRAM port that same cycle; ld_busy tracks busy.
REQ-026 CPU read: after load_done, cpu_addr=15'h7FFC with SDRAM returning 8'h12 -> addr=23'hFFFC, rw=0, one in_valid pulse, cpu_ack pulses once with cpu_data=8'h12.
REQ-027 Contention: cpu_req and ppu_req held high together for 4 transactions -> grant order PPU, CPU, PPU, CPU.
REQ-028 Backpressure: busy=1 for 5 cycles in ISSUE -> no in_valid until busy falls, then exactly one pulse.
REQ-029 Reset mid-WAIT -> FSM in LOAD, no ack, and a subsequent out_valid is ignored.
REQ-030 With ROM_CACHE_EN: two consecutive PPU reads of 13'h0010 -> one SDRAM access; second ack arrives 2 cycles after its request with identical data.
